// File: rtl/mem_wb_resolve_pkg.sv
// Shared constants, write-back record and helpers for the MEM/WB back half of the
// dual-issue pipeline.
package mem_wb_resolve_pkg;

   localparam int DW  = 32;
   localparam int PCW = 10;

   localparam logic [2:0] FW_RF = 3'd0;
   localparam logic [2:0] FW_M2 = 3'd1;
   localparam logic [2:0] FW_M1 = 3'd2;
   localparam logic [2:0] FW_W1 = 3'd3;
   localparam logic [2:0] FW_W2 = 3'd4;

   typedef struct packed {
      logic           rw;
      logic           jal;
      logic           m2r;
      logic [4:0]     dst;
      logic [DW-1:0]  alu;
      logic [PCW-1:0] ra;
   } wb_lane_t;

   // Youngest producer wins: lane2 is later in program order than lane1,
   // and MEM is younger than WB.
   function automatic logic [2:0] fw_pick(input logic m2, input logic m1,
                                          input logic w2, input logic w1);
      if (m2)      return FW_M2;
      else if (m1) return FW_M1;
      else if (w2) return FW_W2;
      else if (w1) return FW_W1;
      else         return FW_RF;
   endfunction

   function automatic logic [DW-1:0] link_word(input logic [PCW-1:0] ra);
      return {{(DW-PCW){1'b0}}, ra};
   endfunction

endpackage

// File: rtl/mem_wb_resolve_dmem_2w.sv
// Dual-write, dual-read synchronous data RAM. Lane2 wins same-word write
// collisions, and a lane2 read sees lane1's same-cycle store.
module dmem_2w
   import mem_wb_resolve_pkg::*;
#(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we1_i,
   input  logic          re1_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wd1_i,
   input  logic          we2_i,
   input  logic          re2_i,
   input  logic [AW-1:0] addr2_i,
   input  logic [DW-1:0] wd2_i,
   output logic [DW-1:0] rd1_o,
   output logic [DW-1:0] rd2_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd1_q, rd2_q;

   // Lane2 written last so it takes the word on a collision.
   always_ff @(posedge clk_i) begin
      if (we1_i) mem_q[addr1_i] <= wd1_i;
      if (we2_i) mem_q[addr2_i] <= wd2_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         if (re1_i) rd1_q <= mem_q[addr1_i];
         if (re2_i) rd2_q <= (we1_i && (addr1_i == addr2_i)) ? wd1_i : mem_q[addr2_i];
      end
   end

   assign rd1_o = rd1_q;
   assign rd2_o = rd2_q;

endmodule

// File: rtl/mem_wb_resolve.sv
// MEM and WB stages for both lanes: data memory access, MEM/WB registers,
// EX forwarding selects and taken-branch redirect/flush.
module mem_wb_resolve
   import mem_wb_resolve_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           MemReadEn1_MEM,
   input  logic           MemtoReg1_MEM,
   input  logic           MemWriteEn1_MEM,
   input  logic           RegWriteEn1_MEM,
   input  logic           jal1_MEM,
   input  logic           taken1_MEM,
   input  logic           MemReadEn2_MEM,
   input  logic           MemtoReg2_MEM,
   input  logic           MemWriteEn2_MEM,
   input  logic           RegWriteEn2_MEM,
   input  logic           jal2_MEM,
   input  logic           taken2_MEM,
   input  logic [4:0]     DestReg1_MEM,
   input  logic [4:0]     DestReg2_MEM,
   input  logic [4:0]     rs1_EX,
   input  logic [4:0]     rs2_EX,
   input  logic [4:0]     rt1_EX,
   input  logic [4:0]     rt2_EX,
   input  logic [9:0]     return_addr1_MEM,
   input  logic [9:0]     return_addr2_MEM,
   input  logic [9:0]     target1_MEM,
   input  logic [9:0]     target2_MEM,
   input  logic [31:0]    aluRes1_MEM,
   input  logic [31:0]    aluRes2_MEM,
   input  logic [31:0]    forwardBRes1_MEM,
   input  logic [31:0]    forwardBRes2_MEM,
   output logic           regWrite1_WB,
   output logic           regWrite2_WB,
   output logic           jal1_WB,
   output logic           jal2_WB,
   output logic [4:0]     writeReg1_WB,
   output logic [4:0]     writeReg2_WB,
   output logic [31:0]    writeData1_WB,
   output logic [31:0]    writeData2_WB,
   output logic [31:0]    aluRes1_WB,
   output logic [31:0]    aluRes2_WB,
   output logic [31:0]    aluRes1_MEM_fwd,
   output logic [31:0]    aluRes2_MEM_fwd,
   output logic [2:0]     ForwardA_1,
   output logic [2:0]     ForwardA_2,
   output logic [2:0]     ForwardB_1,
   output logic [2:0]     ForwardB_2,
   output logic           correct_en,
   output logic           flush_IFID,
   output logic           flush_IDEX,
   output logic [9:0]     correction
);

   localparam int AW = $clog2(DEPTH);

   logic          squash_q, squash_d;
   logic          run, v1, v2, tk1, tk2;
   logic          mfw1, mfw2;
   logic [DW-1:0] rdata1, rdata2;
   wb_lane_t      wb1_d, wb1_q, wb2_d, wb2_q;

   // Combinational outputs are held at zero while reset is asserted.
   assign run = rst;
   assign v1  = run && !squash_q;
   assign v2  = v1 && !taken1_MEM;
   assign tk1 = v1 && taken1_MEM;
   assign tk2 = v2 && taken2_MEM;

   assign correct_en = tk1 || tk2;
   assign correction = tk1 ? target1_MEM : (tk2 ? target2_MEM : '0);
   assign flush_IFID = correct_en;
   assign flush_IDEX = correct_en;
   assign squash_d   = correct_en;

   dmem_2w #(.DEPTH(DEPTH)) u_dmem (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we1_i   (v1 && MemWriteEn1_MEM),
      .re1_i   (v1 && MemReadEn1_MEM),
      .addr1_i (aluRes1_MEM[AW+1:2]),
      .wd1_i   (forwardBRes1_MEM),
      .we2_i   (v2 && MemWriteEn2_MEM),
      .re2_i   (v2 && MemReadEn2_MEM),
      .addr2_i (aluRes2_MEM[AW+1:2]),
      .wd2_i   (forwardBRes2_MEM),
      .rd1_o   (rdata1),
      .rd2_o   (rdata2)
   );

   always_comb begin
      wb1_d     = '0;
      wb1_d.rw  = v1 && RegWriteEn1_MEM && (|DestReg1_MEM);
      wb1_d.jal = v1 && jal1_MEM;
      wb1_d.m2r = MemtoReg1_MEM;
      wb1_d.dst = DestReg1_MEM;
      wb1_d.alu = aluRes1_MEM;
      wb1_d.ra  = return_addr1_MEM;
      wb2_d     = '0;
      wb2_d.rw  = v2 && RegWriteEn2_MEM && (|DestReg2_MEM);
      wb2_d.jal = v2 && jal2_MEM;
      wb2_d.m2r = MemtoReg2_MEM;
      wb2_d.dst = DestReg2_MEM;
      wb2_d.alu = aluRes2_MEM;
      wb2_d.ra  = return_addr2_MEM;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         squash_q <= 1'b0;
         wb1_q    <= '0;
         wb2_q    <= '0;
      end else begin
         squash_q <= squash_d;
         wb1_q    <= wb1_d;
         wb2_q    <= wb2_d;
      end
   end

   assign regWrite1_WB  = wb1_q.rw;
   assign regWrite2_WB  = wb2_q.rw;
   assign jal1_WB       = wb1_q.jal;
   assign jal2_WB       = wb2_q.jal;
   assign writeReg1_WB  = wb1_q.dst;
   assign writeReg2_WB  = wb2_q.dst;
   assign aluRes1_WB    = wb1_q.alu;
   assign aluRes2_WB    = wb2_q.alu;
   assign writeData1_WB = wb1_q.jal ? link_word(wb1_q.ra) : (wb1_q.m2r ? rdata1 : wb1_q.alu);
   assign writeData2_WB = wb2_q.jal ? link_word(wb2_q.ra) : (wb2_q.m2r ? rdata2 : wb2_q.alu);

   assign aluRes1_MEM_fwd = !run ? '0 : (jal1_MEM ? link_word(return_addr1_MEM) : aluRes1_MEM);
   assign aluRes2_MEM_fwd = !run ? '0 : (jal2_MEM ? link_word(return_addr2_MEM) : aluRes2_MEM);

   // Loads cannot forward from MEM: their data only exists in WB.
   assign mfw1 = v1 && RegWriteEn1_MEM && !MemtoReg1_MEM && (|DestReg1_MEM);
   assign mfw2 = v2 && RegWriteEn2_MEM && !MemtoReg2_MEM && (|DestReg2_MEM);

   assign ForwardA_1 = fw_pick(mfw2 && (DestReg2_MEM == rs1_EX), mfw1 && (DestReg1_MEM == rs1_EX),
                               wb2_q.rw && (wb2_q.dst == rs1_EX), wb1_q.rw && (wb1_q.dst == rs1_EX));
   assign ForwardB_1 = fw_pick(mfw2 && (DestReg2_MEM == rt1_EX), mfw1 && (DestReg1_MEM == rt1_EX),
                               wb2_q.rw && (wb2_q.dst == rt1_EX), wb1_q.rw && (wb1_q.dst == rt1_EX));
   assign ForwardA_2 = fw_pick(mfw2 && (DestReg2_MEM == rs2_EX), mfw1 && (DestReg1_MEM == rs2_EX),
                               wb2_q.rw && (wb2_q.dst == rs2_EX), wb1_q.rw && (wb1_q.dst == rs2_EX));
   assign ForwardB_2 = fw_pick(mfw2 && (DestReg2_MEM == rt2_EX), mfw1 && (DestReg1_MEM == rt2_EX),
                               wb2_q.rw && (wb2_q.dst == rt2_EX), wb1_q.rw && (wb1_q.dst == rt2_EX));

endmodule
